// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encoding, winner codes,
// the vertical-blanking start line and score/frame counter widths.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int V_BLANK_START = 480;
  localparam int SCORE_W       = 4;
  localparam int FRAME_CNT_W   = 8;

  // Scores stop at their maximum instead of wrapping to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-clock pulse on the first cycle the scan position reaches the start of
// vertical blanking; a position held for several clocks yields a single pulse.
module frame_tick_gen
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       frame_tick
);

  logic vb_start;
  logic vb_start_q;

  assign vb_start = (pixel_x == 10'd0) && (pixel_y == 10'(V_BLANK_START));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_start_q <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vb_start_q <= vb_start;
      frame_tick <= vb_start && !vb_start_q;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start button, serve/point frame timers, scoring and winner.
//   state | meaning
//   IDLE  | waiting for start; last game's scores still shown
//   SERVE | ball centred, counting SERVE_FRAMES frames before release
//   PLAY  | ball in motion, watching for misses
//   POINT | a point was scored; check for win, else pause POINT_FRAMES frames
//   OVER  | game won; scores and winner frozen until start
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 120
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   pixel_x,
  input  logic [9:0]   pixel_y,
  input  logic         btn_start,
  input  logic         miss_l,
  input  logic         miss_r,
  output logic         frame_tick,
  output logic         ball_en,
  output logic         ball_rst,
  output logic [3:0]   score_l,
  output logic [3:0]   score_r,
  output logic [1:0]   winner,
  output logic [2:0]   state
);

  localparam logic [SCORE_W-1:0]     WIN_VAL = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_N = FRAME_CNT_W'(SERVE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] POINT_N = FRAME_CNT_W'(POINT_FRAMES);

  state_t                 state_q;
  logic [2:0]             btn_sync;
  logic                   start_evt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt_inc;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_tick (frame_tick)
  );

  // btn_sync[1:0] is the two-flop synchronizer, btn_sync[2] holds the previous sample.
  assign start_evt     = btn_sync[1] & ~btn_sync[2];
  assign frame_cnt_inc = frame_cnt + 1'b1;
  assign state         = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      btn_sync  <= '0;
      frame_cnt <= '0;
      score_l   <= '0;
      score_r   <= '0;
      winner    <= WIN_NONE;
      ball_en   <= 1'b0;
      ball_rst  <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[1:0], btn_start};
      ball_en  <= 1'b0;
      ball_rst <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_evt) begin
            state_q   <= ST_SERVE;
            score_l   <= '0;
            score_r   <= '0;
            winner    <= WIN_NONE;
            frame_cnt <= '0;
            ball_rst  <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            frame_cnt <= frame_cnt_inc;
            if (frame_cnt_inc == SERVE_N) begin
              state_q <= ST_PLAY;
              ball_en <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          frame_cnt <= '0;
          if (miss_l && miss_r) begin
            // Simultaneous misses are a void rally: re-serve with no score.
            state_q  <= ST_SERVE;
            ball_rst <= 1'b1;
          end else if (miss_r) begin
            score_l <= sat_inc(score_l);
            state_q <= ST_POINT;
          end else if (miss_l) begin
            score_r <= sat_inc(score_r);
            state_q <= ST_POINT;
          end else begin
            ball_en <= 1'b1;
          end
        end
        ST_POINT: begin
          if (score_l == WIN_VAL) begin
            winner  <= WIN_LEFT;
            state_q <= ST_OVER;
          end else if (score_r == WIN_VAL) begin
            winner  <= WIN_RIGHT;
            state_q <= ST_OVER;
          end else if (frame_tick) begin
            if (frame_cnt_inc == POINT_N) begin
              frame_cnt <= '0;
              ball_rst  <= 1'b1;
              state_q   <= ST_SERVE;
            end else begin
              frame_cnt <= frame_cnt_inc;
            end
          end
        end
        ST_OVER: begin
          if (start_evt) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-002 Parameter WIN_SCORE, default 7: points that end a game (range 1-15).
REQ-003 Parameter SERVE_FRAMES, default 60: frames held in SERVE before ball release.
REQ-004 Parameter POINT_FRAMES, default 120: frames held in POINT after a score.
REQ-005 clk  input  1  100 MHz system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 pixel_x  input  10  current horizontal scan count from the sync generator.
REQ-008 pixel_y  input  10  current vertical scan count from the sync generator.
REQ-009 btn_start  input  1  raw asynchronous start button.
REQ-010 miss_l  input  1  single-cycle pulse: ball passed left paddle (right player scores).
REQ-011 miss_r  input  1  single-cycle pulse: ball passed right paddle (left player scores).
REQ-012 frame_tick  output  1  one-cycle pulse at start of vertical blanking.
REQ-013 ball_en  output  1  ball/paddle motion enable; high only in PLAY.
REQ-014 ball_rst  output  1  one-cycle pulse requesting ball re-centre.
REQ-015 score_l, score_r  output  4 each  player scores.
REQ-016 winner  output  2  00 none, 01 left, 10 right.
REQ-017 state  output  3  encoded FSM state for text/overlay logic.

Function
REQ-018 frame_tick SHALL pulse for exactly one clk on the first cycle in which (pixel_x==0 && pixel_y==480) becomes true; the condition persisting across several clk cycles SHALL NOT produce additional pulses.
REQ-019 btn_start SHALL pass through a 2-flop synchronizer; only a synchronized rising edge (start_evt) SHALL be used.
REQ-020 FSM states: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; other codes SHALL return to IDLE on the next clk.
REQ-021 IDLE: start_evt -> SERVE; scores cleared to 0, winner=00, ball_rst pulsed on the transition cycle.
REQ-022 SERVE: 8-bit frame counter cleared on entry and incremented per frame_tick; on reaching SERVE_FRAMES -> PLAY.
REQ-023 PLAY: ball_en=1; miss_r alone -> score_l+1; miss_l alone -> score_r+1; either -> POINT.
REQ-024 PLAY: miss_l and miss_r in the same cycle -> no score change, -> SERVE with ball_rst pulsed.
REQ-025 POINT: if the incremented score equals WIN_SCORE -> OVER with winner set; otherwise hold POINT_FRAMES frames, pulse ball_rst, -> SERVE.
REQ-026 OVER: scores and winner held; start_evt -> IDLE on that cycle, then IDLE behaviour applies.
REQ-027 miss pulses outside PLAY and start_evt outside IDLE/OVER SHALL be ignored.
REQ-028 Scores SHALL saturate at 15 and never wrap.
REQ-029 All outputs SHALL be registered; state change latency is 1 clk from the triggering event.

Reset
REQ-030 On rst: state=IDLE, score_l=score_r=0, winner=00, frame counter=0, synchronizer=0, frame_tick=ball_en=ball_rst=0.
REQ-031 rst asserted mid-game SHALL abandon the game immediately with no ball_rst pulse.

Structure
REQ-032 Shared package pong_pkg SHALL hold the state encoding, winner codes, V_BLANK_START=480, and score width.
REQ-033 Frame-tick detection SHALL be a sub-module frame_tick_gen (clk, rst, pixel_x, pixel_y -> frame_tick).
REQ-034 Frame counter SHALL be 8 bits; SERVE_FRAMES and POINT_FRAMES SHALL be limited to 1-255.

Verification
REQ-035 Reset, then pixel_y=480, pixel_x=0 held 4 clk -> exactly one frame_tick pulse.
REQ-036 start pulse in IDLE -> SERVE, ball_rst for 1 clk, ball_en=1 after 60 frame_ticks.
REQ-037 PLAY, miss_r pulse -> score_l=1, state=POINT; after 120 ticks ball_rst pulses and state=SERVE.
REQ-038 score_r=6 with WIN_SCORE=7, miss_l -> score_r=7, winner=10, state=OVER; later misses do not change scores.
REQ-039 miss_l and miss_r in the same PLAY cycle -> scores unchanged, state=SERVE.
REQ-040 rst asserted in PLAY with score 3:2 -> state=IDLE, scores 0:0, ball_en=0 without waiting for clk.
